operand_split_fifo: RTL and testbench
=====================================

OPERAND_SPLIT_FIFO -- requirements
Module: operand_split_fifo

Interface
REQ-001 Parameter DATA_IN_WIDTH, default 8, operand width in bits.
REQ-002 Parameter DEPTH, default 4, entries per branch FIFO; power of two, at least 2.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 arst_n  input  1  asynchronous active-low reset.
REQ-005 in_data  input  2*DATA_IN_WIDTH  packed operand pair; low half is operand A, high half is operand B.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 out_a  output  DATA_IN_WIDTH  head of branch A.
REQ-009 out_a_valid  output  1  branch A non-empty.
REQ-010 out_a_ready  input  1  sink A accepts.
REQ-011 out_b, out_b_valid, out_b_ready SHALL be identical in form to REQ-008..010, for branch B.
REQ-012 a_count, b_count  output  $clog2(DEPTH)+1  occupancy of each branch FIFO.

Function
REQ-013 Input handshake SHALL be in_valid and in_ready high at a rising edge; output handshake SHALL be out_x_valid and out_x_ready high at a rising edge.
REQ-014 in_ready SHALL equal (a_count < DEPTH) and (b_count < DEPTH); it is independent of in_valid and of the output readies.
REQ-015 On an input handshake, in_data low half SHALL be pushed to branch A and high half to branch B in the same edge; a pair is never split across cycles.
REQ-016 Each branch SHALL be first-word-fall-through: out_x is the head entry and out_x_valid = (x_count != 0), both driven from registers or memory with no combinational path from in_data or in_valid.
REQ-017 Latency SHALL be one cycle: a word accepted at edge N is presented on out_a/out_b from edge N onward.
REQ-018 Branches SHALL drain independently; a branch may run ahead of the other by up to DEPTH entries.
REQ-019 Push and pop on the same branch at the same edge SHALL leave its count unchanged and SHALL preserve order.
REQ-020 When a branch is full, no input is accepted, even if that branch pops in the same cycle (no full-bypass).
REQ-021 Out-valid SHALL stay high and out data SHALL stay stable until the handshake completes.
REQ-022 Read and write pointers SHALL be $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full = equal index with differing MSB; empty = pointers equal.
REQ-023 Each branch SHALL emit data in exact push order with no loss or duplication.

Reset
REQ-024 Asserting arst_n low SHALL asynchronously clear all pointers and counts. out_a_valid=0, out_b_valid=0, a_count=0, b_count=0, in_ready=1.
REQ-025 Reset mid-operation SHALL discard all buffered entries; storage contents need not be cleared.
REQ-026 The first handshake after reset release SHALL behave as on an empty block.

Structure
REQ-027 Shared package alu_fifo_pkg SHALL hold the DATA_IN_WIDTH and DEPTH defaults and a packed operand-pair typedef (fields a, b).
REQ-028 Each branch SHALL be one instance of sub-module split_branch_fifo (one push port, one pop port, count output). The top contains only the instances and the in_ready logic.

Verification (DATA_IN_WIDTH=8, DEPTH=4)
REQ-029 Reset: arst_n low with in_valid=1 -> out_a_valid=out_b_valid=0, counts 0, in_ready=1, and nothing is pushed while in reset.
REQ-030 Single word: in_data=16'hA55A, both readies 1 -> next cycle out_a=8'h5A and out_b=8'hA5, both valid; valid drops one cycle later.
REQ-031 Skew/full: out_a_ready=1, out_b_ready=0, push 16'h0100, 0201, 0302, 0403.
  - Expected: A emits 00,01,02,03; b_count=4; in_ready=0; a 5th word 16'h0504 is held.
  - Then raise out_b_ready: B emits 01,02,03,04, and 16'h0504 is accepted one cycle after b_count drops to 3.
REQ-032 Simultaneous: with a_count=2, push and pop A in the same cycle -> a_count stays 2 and the popped value is the oldest entry.
REQ-033 Reset mid-operation: at a_count=3, pulse arst_n low -> counts 0 and valids 0 immediately. After release, push 16'h1234 -> out_a=8'h34, out_b=8'h12.
REQ-034 Random: 1000 random pairs with random in_valid and random readies -> the A stream equals the low halves and the B stream equals the high halves, in order; 1000/1000 match.

Source files
------------

// File: rtl/alu_fifo_pkg.sv
// Shared defaults and the packed operand-pair type for the operand split FIFO.
package alu_fifo_pkg;

  localparam int unsigned DataInWidth = 8;
  localparam int unsigned Depth       = 4;

  // Operand B sits in the high half, operand A in the low half.
  typedef struct packed {
    logic [DataInWidth-1:0] b;
    logic [DataInWidth-1:0] a;
  } operand_pair_t;

endpackage

// File: rtl/split_branch_fifo.sv
// One first-word-fall-through branch FIFO with wrap-bit pointers and an occupancy count.
module split_branch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             arst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [PtrW-1:0]  count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic             full, empty, do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW-2:0] == rd_ptr_q[PtrW-2:0]) &&
                 (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]);

  // A full branch never takes a word, even when it pops in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop_ready && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
  end

  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-2:0]] <= push_data;
  end

  assign pop_data  = mem_q[rd_ptr_q[PtrW-2:0]];
  assign pop_valid = !empty;
  assign count     = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/operand_split_fifo.sv
// Splits each accepted operand pair into two independently drained branch FIFOs.
module operand_split_fifo
  import alu_fifo_pkg::*;
#(
  parameter int unsigned DATA_IN_WIDTH = DataInWidth,
  parameter int unsigned DEPTH         = Depth,
  localparam int unsigned CntW         = $clog2(DEPTH) + 1
) (
  input  logic                       clk_i,
  input  logic                       arst_n,
  input  logic [2*DATA_IN_WIDTH-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_IN_WIDTH-1:0]   out_a,
  output logic                       out_a_valid,
  input  logic                       out_a_ready,
  output logic [DATA_IN_WIDTH-1:0]   out_b,
  output logic                       out_b_valid,
  input  logic                       out_b_ready,
  output logic [CntW-1:0]            a_count,
  output logic [CntW-1:0]            b_count
);

  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  logic push;

  // Both halves must have room so a pair is never split across cycles.
  assign in_ready = (a_count < FullCount) && (b_count < FullCount);
  assign push     = in_valid && in_ready;

  split_branch_fifo #(
    .WIDTH (DATA_IN_WIDTH),
    .DEPTH (DEPTH)
  ) u_branch_a (
    .clk_i     (clk_i),
    .arst_n    (arst_n),
    .push      (push),
    .push_data (in_data[DATA_IN_WIDTH-1:0]),
    .pop_data  (out_a),
    .pop_valid (out_a_valid),
    .pop_ready (out_a_ready),
    .count     (a_count)
  );

  split_branch_fifo #(
    .WIDTH (DATA_IN_WIDTH),
    .DEPTH (DEPTH)
  ) u_branch_b (
    .clk_i     (clk_i),
    .arst_n    (arst_n),
    .push      (push),
    .push_data (in_data[2*DATA_IN_WIDTH-1:DATA_IN_WIDTH]),
    .pop_data  (out_b),
    .pop_valid (out_b_valid),
    .pop_ready (out_b_ready),
    .count     (b_count)
  );

endmodule

// File: tb/tb_operand_split_fifo.sv
// Scoreboard bench for operand_split_fifo: directed scenarios plus a randomized stream.
module tb_operand_split_fifo;
  import alu_fifo_pkg::*;

  logic        clk_i = 1'b0;
  logic        arst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_a, out_b;
  logic        out_a_valid, out_b_valid;
  logic        out_a_ready = 1'b0;
  logic        out_b_ready = 1'b0;
  logic [2:0]  a_count, b_count;

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int a_pops = 0;
  int b_pops = 0;

  // Reference model: each branch is simply an ordered queue of pushed halves.
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  operand_split_fifo #(
    .DATA_IN_WIDTH (8),
    .DEPTH         (4)
  ) dut (
    .clk_i       (clk_i),
    .arst_n      (arst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_a       (out_a),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready),
    .out_b       (out_b),
    .out_b_valid (out_b_valid),
    .out_b_ready (out_b_ready),
    .a_count     (a_count),
    .b_count     (b_count)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: mid-cycle, compares against the model and commits handshakes due at the next edge.
  always @(negedge clk_i) begin
    if (!arst_n) begin
      exp_a.delete();
      exp_b.delete();
    end else begin
      check("a_count", int'(a_count), exp_a.size());
      check("b_count", int'(b_count), exp_b.size());
      check("in_ready", int'(in_ready), int'(exp_a.size() < 4 && exp_b.size() < 4));
      check("a_valid", int'(out_a_valid), int'(exp_a.size() != 0));
      check("b_valid", int'(out_b_valid), int'(exp_b.size() != 0));
      if (out_a_valid && exp_a.size() != 0) check("a_data", int'(out_a), int'(exp_a[0]));
      if (out_b_valid && exp_b.size() != 0) check("b_data", int'(out_b), int'(exp_b[0]));
      if (out_a_valid && out_a_ready && exp_a.size() != 0) begin
        void'(exp_a.pop_front());
        a_pops++;
      end
      if (out_b_valid && out_b_ready && exp_b.size() != 0) begin
        void'(exp_b.pop_front());
        b_pops++;
      end
      if (in_valid && in_ready) begin
        exp_a.push_back(in_data[7:0]);
        exp_b.push_back(in_data[15:8]);
        pushes++;
      end
    end
  end

  task automatic drain();
    in_valid    = 1'b0;
    out_a_ready = 1'b1;
    out_b_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
  endtask

  initial begin
    operand_pair_t pair;
    int base_push, base_a, base_b, cyc;

    // Reset with in_valid asserted: nothing may enter.
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    repeat (3) tick();
    check("rst_a_valid", int'(out_a_valid), 0);
    check("rst_b_valid", int'(out_b_valid), 0);
    check("rst_a_count", int'(a_count), 0);
    check("rst_b_count", int'(b_count), 0);
    check("rst_in_ready", int'(in_ready), 1);
    in_valid = 1'b0;
    arst_n   = 1'b1;
    tick();
    check("post_rst_a_count", int'(a_count), 0);

    // Single word with both sinks ready.
    out_a_ready = 1'b1;
    out_b_ready = 1'b1;
    pair.a = 8'h5A;
    pair.b = 8'hA5;
    in_data  = pair;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_out_a", int'(out_a), 8'h5A);
    check("single_out_b", int'(out_b), 8'hA5);
    check("single_a_valid", int'(out_a_valid), 1);
    check("single_b_valid", int'(out_b_valid), 1);
    tick();
    check("single_a_drop", int'(out_a_valid), 0);
    check("single_b_drop", int'(out_b_valid), 0);

    // Skew until B is full, then hold a fifth word.
    out_a_ready = 1'b1;
    out_b_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data  = {8'(i + 1), 8'(i)};
      in_valid = 1'b1;
      tick();
    end
    in_data = 16'h0504;
    tick();
    tick();
    check("skew_b_count_full", int'(b_count), 4);
    check("skew_in_ready_low", int'(in_ready), 0);
    check("skew_a_count", int'(a_count), 0);
    out_b_ready = 1'b1;
    tick();
    check("skew_b_count_3", int'(b_count), 3);
    check("skew_in_ready_high", int'(in_ready), 1);
    check("skew_held_not_yet", int'(a_count), 0);
    tick();
    in_valid = 1'b0;
    check("skew_accept_a_count", int'(a_count), 1);
    check("skew_accept_out_a", int'(out_a), 8'h04);
    check("skew_accept_b_count", int'(b_count), 3);
    drain();

    // Simultaneous push and pop on A at a_count=2.
    out_a_ready = 1'b0;
    out_b_ready = 1'b0;
    in_valid    = 1'b1;
    in_data     = 16'h2010;
    tick();
    in_data = 16'h2111;
    tick();
    check("simul_pre_a_count", int'(a_count), 2);
    in_data     = 16'h2212;
    out_a_ready = 1'b1;
    tick();
    in_valid    = 1'b0;
    out_a_ready = 1'b0;
    check("simul_a_count", int'(a_count), 2);
    check("simul_new_head", int'(out_a), 8'h11);
    check("simul_b_count", int'(b_count), 3);
    drain();

    // Reset in the middle of operation.
    out_a_ready = 1'b0;
    out_b_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data  = 16'h7700 + 16'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("midrst_pre_a_count", int'(a_count), 3);
    #2;
    arst_n = 1'b0;
    #1;
    check("midrst_a_count", int'(a_count), 0);
    check("midrst_b_count", int'(b_count), 0);
    check("midrst_a_valid", int'(out_a_valid), 0);
    check("midrst_b_valid", int'(out_b_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    tick();
    arst_n      = 1'b1;
    out_a_ready = 1'b1;
    out_b_ready = 1'b1;
    in_data     = 16'h1234;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    check("midrst_out_a", int'(out_a), 8'h34);
    check("midrst_out_b", int'(out_b), 8'h12);
    drain();

    // Randomized stream: 1000 accepted pairs with random valid and readies.
    base_push = pushes;
    base_a    = a_pops;
    base_b    = b_pops;
    cyc       = 0;
    while ((pushes - base_push) < 1000 && cyc < 30000) begin
      in_data     = 16'($urandom);
      in_valid    = 1'($urandom_range(0, 1));
      out_a_ready = ($urandom_range(0, 3) != 0);
      out_b_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    check("rand_accepted", pushes - base_push, 1000);
    in_valid    = 1'b0;
    out_a_ready = 1'b1;
    out_b_ready = 1'b1;
    cyc = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && cyc < 100) begin
      tick();
      cyc++;
    end
    tick();
    check("rand_a_popped", a_pops - base_a, 1000);
    check("rand_b_popped", b_pops - base_b, 1000);
    check("rand_final_a_count", int'(a_count), 0);
    check("rand_final_b_count", int'(b_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
